regfile_wr_arbiter: RTL and testbench

Shares the single register-file write port (rw, busW, regWr) between two writeback requesters: the ALU path (A) and the load/memory path (M). Each requester uses a valid/ready handshake. The block arbitrates between them and registers the winning write into a one-stage output register that drives the register file directly. It sits between the execute/memory stages and the register file, and optionally provides read-after-write forwarding for the cycle in which a write is in flight.

---
 rtl/regfile_wr_arbiter_pkg.sv | 10 +
 rtl/regfile_wr_arbiter_if.sv | 31 +++
 rtl/regfile_wr_arbiter_fwd_mux.sv | 18 +
 rtl/regfile_wr_arbiter.sv | 52 +++++
 tb/tb_regfile_wr_arbiter.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/regfile_wr_arbiter_pkg.sv
// regfile_pkg: shared widths, types and arbitration encodings for the register-file write arbiter
package regfile_pkg;
  localparam int NREG_LOG2 = 5;
  localparam int DW = 32;
  typedef logic [NREG_LOG2-1:0] reg_idx_t;
  typedef logic [DW-1:0] word_t;
  localparam int REG_ZERO = 0;
  localparam int ARB_RR = 0;
  localparam int ARB_FIXED_M = 1;
endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// regfile_wr_arbiter_if: requester handshakes plus register-file write/read ports
// Read-forwarding signals exist only when REGFILE_WR_ARB_FWD_EN is defined.
interface regfile_wr_arbiter_if #(
  parameter int NREG_LOG2 = regfile_pkg::NREG_LOG2,
  parameter int DW = regfile_pkg::DW
);
  logic a_valid, a_ready, m_valid, m_ready, regWr;
  logic [NREG_LOG2-1:0] a_rw, m_rw, rw;
  logic [DW-1:0] a_data, m_data, busW;
`ifdef REGFILE_WR_ARB_FWD_EN
  logic [NREG_LOG2-1:0] ra, rb;
  logic [DW-1:0] rf_busA, rf_busB, busA, busB;
  modport master (
    output a_valid, a_rw, a_data, m_valid, m_rw, m_data, ra, rb, rf_busA, rf_busB,
    input a_ready, m_ready, rw, busW, regWr, busA, busB
  );
  modport slave (
    input a_valid, a_rw, a_data, m_valid, m_rw, m_data, ra, rb, rf_busA, rf_busB,
    output a_ready, m_ready, rw, busW, regWr, busA, busB
  );
`else
  modport master (
    output a_valid, a_rw, a_data, m_valid, m_rw, m_data,
    input a_ready, m_ready, rw, busW, regWr
  );
  modport slave (
    input a_valid, a_rw, a_data, m_valid, m_rw, m_data,
    output a_ready, m_ready, rw, busW, regWr
  );
`endif
endinterface

// File: rtl/regfile_wr_arbiter_fwd_mux.sv
// regfile_fwd_mux: one read-after-write forwarding comparator and mux
// Only built when REGFILE_WR_ARB_FWD_EN is defined.
`ifdef REGFILE_WR_ARB_FWD_EN
module regfile_fwd_mux #(
  parameter int NREG_LOG2 = regfile_pkg::NREG_LOG2,
  parameter int DW = regfile_pkg::DW
) (
  input  logic                 regWr,
  input  logic [NREG_LOG2-1:0] rw,
  input  logic [NREG_LOG2-1:0] ra,
  input  logic [DW-1:0]        busW,
  input  logic [DW-1:0]        rfBus,
  output logic [DW-1:0]        fwdBus
);
  import regfile_pkg::*;
  always_comb fwdBus = (regWr && rw == ra && ra != NREG_LOG2'(REG_ZERO)) ? busW : rfBus;
endmodule
`endif

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: arbitrates ALU and load writebacks onto the single register-file write port
// Define REGFILE_WR_ARB_FWD_EN to add read-after-write forwarding on busA/busB.
module regfile_wr_arbiter #(
  parameter int ARB_MODE = regfile_pkg::ARB_RR,
  parameter int NREG_LOG2 = regfile_pkg::NREG_LOG2,
  parameter int DW = regfile_pkg::DW
) (
  input logic clk,
  input logic rst_n,
  regfile_wr_arbiter_if.slave bus
);
  import regfile_pkg::*;
  logic pri, grantA, grantM, accept, regWrQ;
  logic [NREG_LOG2-1:0] selRw, rwQ;
  logic [DW-1:0] selData, busWQ;
  always_comb begin
    grantM = bus.m_valid && (ARB_MODE == ARB_FIXED_M || !bus.a_valid || pri);
    grantA = bus.a_valid && !grantM;
    accept = rst_n && (grantA || grantM);
    selRw = grantM ? bus.m_rw : bus.a_rw;
    selData = grantM ? bus.m_data : bus.a_data;
  end
  assign bus.a_ready = rst_n && grantA;
  assign bus.m_ready = rst_n && grantM;
  // pri points at the loser of the last grant; it stays 0 in fixed-priority mode
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pri <= 1'b0;
      regWrQ <= 1'b0;
      rwQ <= '0;
      busWQ <= '0;
    end else begin
      if (accept) begin
        pri <= grantA && ARB_MODE == ARB_RR;
        rwQ <= selRw;
        busWQ <= selData;
      end
      regWrQ <= accept && selRw != NREG_LOG2'(REG_ZERO);
    end
  end
  assign bus.rw = rwQ;
  assign bus.busW = busWQ;
  assign bus.regWr = regWrQ;
`ifdef REGFILE_WR_ARB_FWD_EN
  regfile_fwd_mux #(.NREG_LOG2(NREG_LOG2), .DW(DW)) fwdA (
    .regWr(regWrQ), .rw(rwQ), .ra(bus.ra), .busW(busWQ), .rfBus(bus.rf_busA), .fwdBus(bus.busA)
  );
  regfile_fwd_mux #(.NREG_LOG2(NREG_LOG2), .DW(DW)) fwdB (
    .regWr(regWrQ), .rw(rwQ), .ra(bus.rb), .busW(busWQ), .rfBus(bus.rf_busB), .fwdBus(bus.busB)
  );
`endif
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: drives a round-robin and a fixed-priority arbiter with identical stimulus
// and scoreboards each against its own arbitration model and register-file image.
module tb_regfile_wr_arbiter;
  import regfile_pkg::*;
  typedef struct packed {logic we; logic [4:0] rw; logic [31:0] data;} wr_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  regfile_wr_arbiter_if #(.NREG_LOG2(5), .DW(32)) ifR ();
  regfile_wr_arbiter_if #(.NREG_LOG2(5), .DW(32)) ifF ();
  regfile_wr_arbiter #(.ARB_MODE(ARB_RR), .NREG_LOG2(5), .DW(32)) dutR (.clk(clk), .rst_n(rst_n), .bus(ifR));
  regfile_wr_arbiter #(.ARB_MODE(ARB_FIXED_M), .NREG_LOG2(5), .DW(32)) dutF (.clk(clk), .rst_n(rst_n), .bus(ifF));
  logic [31:0] rfR [32] = '{default: 32'h0};
  logic [31:0] rfF [32] = '{default: 32'h0};
  always @(posedge clk) if (ifR.regWr) rfR[ifR.rw] <= ifR.busW;
  always @(posedge clk) if (ifF.regWr) rfF[ifF.rw] <= ifF.busW;
  wr_t qR[$], qF[$];
  wr_t outR = '0, outF = '0;
  logic priR = 1'b0;
  logic [1:0] gR, gF;
  int checks = 0, errors = 0;

  task automatic cyc(input logic rn, input logic av, input logic [4:0] ar, input logic [31:0] ad,
                     input logic mv, input logic [4:0] mr, input logic [31:0] md,
                     output logic [1:0] obsR, output logic [1:0] obsF);
    logic wm, eMR, eAR, eMF, eAF;
    wr_t e;
    @(negedge clk);
    rst_n = rn;
    ifR.a_valid = av; ifR.a_rw = ar; ifR.a_data = ad; ifR.m_valid = mv; ifR.m_rw = mr; ifR.m_data = md;
    ifF.a_valid = av; ifF.a_rw = ar; ifF.a_data = ad; ifF.m_valid = mv; ifF.m_rw = mr; ifF.m_data = md;
    #1;
    wm = mv && (!av || priR);
    eMR = rn && wm;
    eAR = rn && av && !wm;
    eMF = rn && mv;
    eAF = rn && av && !mv;
    obsR = {ifR.m_ready, ifR.a_ready};
    obsF = {ifF.m_ready, ifF.a_ready};
    checks += 2;
    if (obsR !== {eMR, eAR}) begin errors++; $display("FAIL rr_ready got %b exp %b", obsR, {eMR, eAR}); end
    if (obsF !== {eMF, eAF}) begin errors++; $display("FAIL fixed_ready got %b exp %b", obsF, {eMF, eAF}); end
    if (!rn) begin
      qR.delete(); qF.delete();
      priR = 1'b0; outR = '0; outF = '0;
    end else begin
      if (eAR || eMR) begin
        e.rw = eMR ? mr : ar; e.data = eMR ? md : ad; e.we = e.rw != 5'd0;
        qR.push_back(e);
        priR = eAR;
      end
      if (eAF || eMF) begin
        e.rw = eMF ? mr : ar; e.data = eMF ? md : ad; e.we = e.rw != 5'd0;
        qF.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    if (qR.size() > 0) outR = qR.pop_front(); else outR.we = 1'b0;
    if (qF.size() > 0) outF = qF.pop_front(); else outF.we = 1'b0;
    checks += 2;
    if ({ifR.regWr, ifR.rw, ifR.busW} !== outR) begin
      errors++;
      $display("FAIL rr_out got we=%b rw=%0d busW=%h exp we=%b rw=%0d busW=%h", ifR.regWr, ifR.rw, ifR.busW, outR.we, outR.rw, outR.data);
    end
    if ({ifF.regWr, ifF.rw, ifF.busW} !== outF) begin
      errors++;
      $display("FAIL fixed_out got we=%b rw=%0d busW=%h exp we=%b rw=%0d busW=%h", ifF.regWr, ifF.rw, ifF.busW, outF.we, outF.rw, outF.data);
    end
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, gR, gF);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, gR, gF);
    cyc(1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, gR, gF);
    checks++;
    if (gR !== 2'b01) begin errors++; $display("FAIL reset_first_grant got %b exp 01", gR); end
    idle();
  endtask

  task automatic test_single();
    cyc(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, gR, gF);
    checks++;
    if (gR !== 2'b01 || gF !== 2'b01) begin errors++; $display("FAIL single_ready got %b/%b exp 01/01", gR, gF); end
    idle();
    checks++;
    if (rfR[5] !== 32'hDEADBEEF || rfF[5] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL single_rf got %h/%h exp deadbeef", rfR[5], rfF[5]);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] seq = '0;
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, gR, gF);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, gR, gF);
      seq = {seq[2:0], gR[1]};
    end
    checks++;
    if (seq !== 4'b0101) begin errors++; $display("FAIL rr_sequence got %b exp 0101", seq); end
    idle();
    checks++;
    if (rfR[3] !== 32'h22 || rfF[3] !== 32'h22) begin errors++; $display("FAIL rr_same_index got %h/%h exp 22", rfR[3], rfF[3]); end
  endtask

  task automatic test_fixed();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 5'd9, 32'hA5, 1'b1, 5'd10, 32'h5A, gR, gF);
      checks++;
      if (gF !== 2'b10) begin errors++; $display("FAIL fixed_m_wins got %b exp 10", gF); end
    end
    cyc(1'b1, 1'b1, 5'd9, 32'hA5, 1'b0, 5'd10, 32'h5A, gR, gF);
    checks++;
    if (gF !== 2'b01) begin errors++; $display("FAIL fixed_a_after_m got %b exp 01", gF); end
    idle();
  endtask

  task automatic test_reg0();
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFFFFFF, gR, gF);
    checks++;
    if (gR[1] !== 1'b1 || gF[1] !== 1'b1) begin errors++; $display("FAIL reg0_ready got %b/%b exp m_ready=1", gR, gF); end
    idle();
    checks++;
    if (rfR[0] !== 32'h0 || rfF[0] !== 32'h0) begin errors++; $display("FAIL reg0_rf got %h/%h exp 0", rfR[0], rfF[0]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [6];
    for (int i = 0; i < 6; i++) begin
      d[i] = $urandom;
      cyc(1'b1, 1'b1, 5'(i + 12), d[i], 1'b0, 5'd0, 32'h0, gR, gF);
    end
    idle();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (rfR[i + 12] !== d[i] || rfF[i + 12] !== d[i]) begin
        errors++; $display("FAIL b2b_rf%0d got %h/%h exp %h", i + 12, rfR[i + 12], rfF[i + 12], d[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    cyc(1'b1, 1'b1, 5'd20, 32'h77, 1'b1, 5'd21, 32'h88, gR, gF);
    cyc(1'b0, 1'b1, 5'd20, 32'h77, 1'b1, 5'd21, 32'h88, gR, gF);
    cyc(1'b1, 1'b1, 5'd20, 32'h77, 1'b1, 5'd21, 32'h88, gR, gF);
    checks++;
    if (gR !== 2'b01) begin errors++; $display("FAIL mid_reset_pri got %b exp 01", gR); end
    idle();
  endtask

`ifdef REGFILE_WR_ARB_FWD_EN
  task automatic test_fwd();
    cyc(1'b1, 1'b1, 5'd7, 32'h1234, 1'b0, 5'd0, 32'h0, gR, gF);
    ifR.ra = 5'd7; ifR.rb = 5'd7; ifR.rf_busA = rfR[7]; ifR.rf_busB = rfR[7];
    #1;
    checks += 2;
    if (ifR.busA !== 32'h1234 || ifR.busB !== 32'h1234) begin
      errors++; $display("FAIL fwd_hit got %h/%h exp 1234", ifR.busA, ifR.busB);
    end
    if (rfR[7] !== 32'h0) begin errors++; $display("FAIL fwd_rf_old got %h exp 0", rfR[7]); end
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h5555, gR, gF);
    ifR.ra = 5'd0; ifR.rf_busA = 32'h0BAD;
    #1;
    checks++;
    if (ifR.busA !== 32'h0BAD) begin errors++; $display("FAIL fwd_reg0 got %h exp 0bad", ifR.busA); end
    idle();
  endtask
`endif

  initial begin
`ifdef REGFILE_WR_ARB_FWD_EN
    ifR.ra = '0; ifR.rb = '0; ifR.rf_busA = '0; ifR.rf_busB = '0;
    ifF.ra = '0; ifF.rb = '0; ifF.rf_busA = '0; ifF.rf_busB = '0;
`endif
    test_reset();
    test_single();
    test_round_robin();
    test_fixed();
    test_reg0();
    test_back_to_back();
    test_mid_reset();
`ifdef REGFILE_WR_ARB_FWD_EN
    test_fwd();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
